// File: rtl/sobolrng_ctrl_pkg.sv
// Shared definitions for the Sobol RNG sequencing controller:
// FSM state encoding and the run-length encoding for a full period.
package sobolrng_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A programmed length of zero requests a full 2^BITWIDTH-sample run
    localparam int LEN_FULL = 0;

endpackage

// File: rtl/sobolrng_lsz.sv
// Least-significant-zero one-hot detector: bit k set where k is the lowest
// zero bit of the input; all-ones input yields zero.
module sobolrng_lsz #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] value,
    output logic [BITWIDTH-1:0] onehot
);

    // Adding one carries through the trailing ones and lands on the lowest zero
    assign onehot = ~value & (value + BITWIDTH'(1));

endmodule

// File: rtl/sobolrng_ctrl.sv
// Sequencing controller for the Sobol RNG core: step counter, LSZ one-hot
// generation and a run-length FSM with start/done, stall and abort.
module sobolrng_ctrl
    import sobolrng_ctrl_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic                iCont,
    input  logic [BITWIDTH-1:0] iLen,
    input  logic                iStall,
    input  logic                iAbort,
    output logic                oEn,
    output logic                oClr,
    output logic [BITWIDTH-1:0] oOneHot,
    output logic [BITWIDTH-1:0] oCnt,
    output logic                oBusy,
    output logic                oLast,
    output logic                oWrap,
    output logic                oDone
);

    state_t              state;
    state_t              state_nxt;
    logic [BITWIDTH-1:0] cnt;
    logic [BITWIDTH:0]   remaining;
    logic [BITWIDTH:0]   len_load;
    logic                cont;
    logic                done;
    logic                step;
    logic                wrap_step;
    logic                last_step;
    logic [BITWIDTH-1:0] lsz_onehot;

    sobolrng_lsz #(
        .BITWIDTH (BITWIDTH)
    ) u_lsz (
        .value  (cnt),
        .onehot (lsz_onehot)
    );

    assign len_load  = (iLen == BITWIDTH'(LEN_FULL)) ? {1'b1, {BITWIDTH{1'b0}}}
                                                    : {1'b0, iLen};
    assign step      = (state == ST_RUN) && !iStall;
    assign wrap_step = (state == ST_RUN) && cont && (&cnt);
    assign last_step = (state == ST_RUN) && !cont && (remaining == (BITWIDTH+1)'(1));

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= step && last_step && !iAbort;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (iStart) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = ST_RUN;
            ST_RUN:  if (step && last_step) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (iAbort && (state != ST_IDLE)) state_nxt = ST_IDLE;
    end

    // Run parameters are captured only when a start is accepted
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt       <= '0;
            remaining <= '0;
            cont      <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && iStart) begin
                cont      <= iCont;
                remaining <= len_load;
            end
            if (state == ST_CLR) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + BITWIDTH'(1);
                if (!cont) remaining <= remaining - (BITWIDTH+1)'(1);
            end
        end
    end

    always_comb begin
        oEn     = 1'b0;
        oClr    = 1'b0;
        oOneHot = '0;
        oLast   = 1'b0;
        oWrap   = 1'b0;
        case (state)
            ST_CLR: oClr = 1'b1;
            ST_RUN: begin
                // The all-ones step in continuous mode clears the core instead of stepping it
                oEn     = !iStall && !wrap_step;
                oClr    = !iStall && wrap_step;
                oOneHot = lsz_onehot;
                oLast   = last_step;
                oWrap   = wrap_step;
            end
            default: ;
        endcase
    end

    assign oBusy = (state != ST_IDLE);
    assign oDone = done;
    assign oCnt  = cnt;

endmodule

// File: tb/tb_sobolrng_ctrl.sv
// Directed bench for sobolrng_ctrl at BITWIDTH=4: a per-cycle vector table
// plus sequences for full-length, continuous, and mid-run reset cases.
module tb_sobolrng_ctrl;

    localparam int BW = 4;

    typedef struct {
        logic       start;
        logic       cont;
        logic [3:0] len;
        logic       stall;
        logic       abort;
        logic       en;
        logic       clr;
        logic [3:0] oh;
        logic [3:0] cnt;
        logic       busy;
        logic       last;
        logic       wrap;
        logic       done;
    } vec_t;

    logic          iClk = 1'b0;
    logic          iRstN = 1'b0;
    logic          iStart = 1'b0;
    logic          iCont = 1'b0;
    logic [BW-1:0] iLen = '0;
    logic          iStall = 1'b0;
    logic          iAbort = 1'b0;
    logic          oEn;
    logic          oClr;
    logic [BW-1:0] oOneHot;
    logic [BW-1:0] oCnt;
    logic          oBusy;
    logic          oLast;
    logic          oWrap;
    logic          oDone;

    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 iClk = ~iClk;

    sobolrng_ctrl #(
        .BITWIDTH (BW)
    ) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iStart  (iStart),
        .iCont   (iCont),
        .iLen    (iLen),
        .iStall  (iStall),
        .iAbort  (iAbort),
        .oEn     (oEn),
        .oClr    (oClr),
        .oOneHot (oOneHot),
        .oCnt    (oCnt),
        .oBusy   (oBusy),
        .oLast   (oLast),
        .oWrap   (oWrap),
        .oDone   (oDone)
    );

    task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic en, input logic clr,
                           input logic [3:0] oh, input logic [3:0] cnt, input logic busy,
                           input logic last, input logic wrap, input logic done);
        chk({tag, ".en"},   idx, 16'(oEn),     16'(en));
        chk({tag, ".clr"},  idx, 16'(oClr),    16'(clr));
        chk({tag, ".oh"},   idx, 16'(oOneHot), 16'(oh));
        chk({tag, ".cnt"},  idx, 16'(oCnt),    16'(cnt));
        chk({tag, ".busy"}, idx, 16'(oBusy),   16'(busy));
        chk({tag, ".last"}, idx, 16'(oLast),   16'(last));
        chk({tag, ".wrap"}, idx, 16'(oWrap),   16'(wrap));
        chk({tag, ".done"}, idx, 16'(oDone),   16'(done));
    endtask

    task automatic drive(input logic st, input logic co, input logic [3:0] len,
                         input logic sl, input logic ab);
        iStart = st;
        iCont  = co;
        iLen   = len;
        iStall = sl;
        iAbort = ab;
    endtask

    task automatic add(input logic st, input logic co, input logic [3:0] len, input logic sl,
                       input logic ab, input logic en, input logic clr, input logic [3:0] oh,
                       input logic [3:0] cnt, input logic busy, input logic last,
                       input logic wrap, input logic done);
        vec_t v;
        v.start = st;  v.cont = co;  v.len = len;  v.stall = sl;  v.abort = ab;
        v.en = en;     v.clr = clr;  v.oh = oh;    v.cnt = cnt;   v.busy = busy;
        v.last = last; v.wrap = wrap; v.done = done;
        vq.push_back(v);
    endtask

    // Lowest clear bit found by scanning, as a one-hot; zero for all-ones
    function automatic logic [3:0] lsz_ref(input logic [3:0] v);
        for (int i = 0; i < BW; i++)
            if (!v[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    initial begin
        logic [3:0]  x;
        logic [3:0]  s1 [16];
        logic [3:0]  s2 [16];
        logic [15:0] mask;
        logic        ew;

        // Finite len=4 run, then a start accepted in the done cycle (len=2)
        add(1,0,4,0,0, 0,0,4'h0,4'd0,0,0,0,0);
        add(0,0,0,0,0, 0,1,4'h0,4'd0,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd0,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h2,4'd1,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd2,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h4,4'd3,1,1,0,0);
        add(1,0,2,0,0, 0,0,4'h0,4'd4,0,0,0,1);
        add(0,0,0,0,0, 0,1,4'h0,4'd4,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd0,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h2,4'd1,1,1,0,0);
        add(0,0,0,0,0, 0,0,4'h0,4'd2,0,0,0,1);
        add(0,0,0,1,0, 0,0,4'h0,4'd2,0,0,0,0);
        // Two-cycle stall at cnt=2
        add(1,0,4,0,0, 0,0,4'h0,4'd2,0,0,0,0);
        add(0,0,0,0,0, 0,1,4'h0,4'd2,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd0,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h2,4'd1,1,0,0,0);
        add(0,0,0,1,0, 0,0,4'h1,4'd2,1,0,0,0);
        add(0,0,0,1,0, 0,0,4'h1,4'd2,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd2,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h4,4'd3,1,1,0,0);
        add(0,0,0,0,0, 0,0,4'h0,4'd4,0,0,0,1);
        // Start pulses during RUN are ignored
        add(1,0,3,0,0, 0,0,4'h0,4'd4,0,0,0,0);
        add(0,0,0,0,0, 0,1,4'h0,4'd4,1,0,0,0);
        add(1,0,1,0,0, 1,0,4'h1,4'd0,1,0,0,0);
        add(1,0,1,0,0, 1,0,4'h2,4'd1,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd2,1,1,0,0);
        add(0,0,0,0,0, 0,0,4'h0,4'd3,0,0,0,1);
        // Abort in RUN, then abort (with stall) in CLR
        add(1,0,4,0,0, 0,0,4'h0,4'd3,0,0,0,0);
        add(0,0,0,0,0, 0,1,4'h0,4'd3,1,0,0,0);
        add(0,0,0,0,0, 1,0,4'h1,4'd0,1,0,0,0);
        add(0,0,0,0,1, 1,0,4'h2,4'd1,1,0,0,0);
        add(0,0,0,0,0, 0,0,4'h0,4'd2,0,0,0,0);
        add(1,0,4,0,0, 0,0,4'h0,4'd2,0,0,0,0);
        add(0,0,0,1,1, 0,1,4'h0,4'd2,1,0,0,0);
        add(0,0,0,0,0, 0,0,4'h0,4'd0,0,0,0,0);

        drive(0,0,0,0,0);
        iRstN = 1'b0;
        repeat (2) @(negedge iClk);
        chk_all("reset", 0, 0,0,4'h0,4'd0,0,0,0,0);
        iRstN = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].start, vq[i].cont, vq[i].len, vq[i].stall, vq[i].abort);
            #1;
            chk_all("vec", i, vq[i].en, vq[i].clr, vq[i].oh, vq[i].cnt,
                    vq[i].busy, vq[i].last, vq[i].wrap, vq[i].done);
            @(negedge iClk);
        end

        // Full-length finite run requested with len=0
        drive(1,0,4'd0,0,0);
        #1 chk_all("full_idle", 0, 0,0,4'h0,4'd0,0,0,0,0);
        @(negedge iClk);
        drive(0,0,0,0,0);
        #1 chk_all("full_clr", 0, 0,1,4'h0,4'd0,1,0,0,0);
        @(negedge iClk);
        for (int k = 0; k < 16; k++) begin
            #1 chk_all("full", k, 1,0,lsz_ref(4'(k)),4'(k),1,(k == 15),0,0);
            @(negedge iClk);
        end
        #1 chk_all("full_done", 0, 0,0,4'h0,4'd0,0,0,0,1);
        @(negedge iClk);

        // Continuous mode with a modelled first-dimension Sobol core
        drive(1,1,4'd5,0,0);
        #1 chk_all("cont_idle", 0, 0,0,4'h0,4'd0,0,0,0,0);
        @(negedge iClk);
        drive(0,0,0,0,0);
        #1 chk_all("cont_clr", 0, 0,1,4'h0,4'd0,1,0,0,0);
        x = 4'd0;
        @(negedge iClk);
        for (int k = 0; k < 40; k++) begin
            if (k == 39) iAbort = 1'b1;
            #1;
            ew = ((k % 16) == 15);
            chk_all("cont", k, !ew, ew, ew ? 4'h0 : lsz_ref(4'(k % 16)), 4'(k % 16), 1, 0, ew, 0);
            if (k < 16) s1[k] = x;
            else if (k < 32) s2[k-16] = x;
            if (oClr) x = 4'd0;
            else if (oEn)
                for (int b = 0; b < BW; b++)
                    if (oOneHot[b]) x = x ^ 4'(8 >> b);
            @(negedge iClk);
        end
        mask = 16'h0000;
        for (int k = 0; k < 16; k++) mask = mask | (16'(1) << s1[k]);
        chk("cont_cover", 0, mask, 16'hFFFF);
        for (int k = 0; k < 16; k++) chk("cont_period", k, 16'(s2[k]), 16'(s1[k]));
        drive(0,0,0,0,0);
        #1 chk_all("cont_abort", 0, 0,0,4'h0,4'd8,0,0,0,0);
        @(negedge iClk);
        #1 chk_all("cont_after", 0, 0,0,4'h0,4'd8,0,0,0,0);
        @(negedge iClk);

        // Asynchronous reset in the middle of a run
        drive(1,0,4'd8,0,0);
        @(negedge iClk);
        drive(0,0,0,0,0);
        repeat (3) @(negedge iClk);
        #1 chk_all("pre_rst", 0, 1,0,4'h1,4'd2,1,0,0,0);
        iRstN = 1'b0;
        #1 chk_all("rst_mid", 0, 0,0,4'h0,4'd0,0,0,0,0);
        @(negedge iClk);
        iRstN = 1'b1;
        #1 chk_all("rst_after", 0, 0,0,4'h0,4'd0,0,0,0,0);
        @(negedge iClk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobolrng_ctrl.md
Name: sobolrng_ctrl

Overview:
Sequencing controller that sits directly upstream of the Sobol RNG core and drives its enable, clear and one-hot inputs.
It contains:
- a step counter;
- a least-significant-zero (LSZ) one-hot detector;
- a run-length FSM with start/done handshake, stall and abort.
A run produces either a programmed number of Sobol samples or a continuous period-2^BITWIDTH stream.

Parameters:
BITWIDTH, 8, width of counter, one-hot vector and run length; must match the downstream core.

Ports:
iClk  in  1  clock
iRstN  in  1  reset, asynchronous, active-low
iStart  in  1  start request; sampled only in IDLE
iCont  in  1  continuous mode, latched at start
iLen  in  BITWIDTH  run length in samples; 0 means 2^BITWIDTH; latched at start; ignored when iCont=1
iStall  in  1  hold the sequence for this cycle
iAbort  in  1  terminate run, return to IDLE
oEn  out  1  core enable
oClr  out  1  core synchronous clear
oOneHot  out  BITWIDTH  one-hot position of least-significant zero of oCnt
oCnt  out  BITWIDTH  current sample index
oBusy  out  1  high in CLR and RUN
oLast  out  1  current RUN step is the final sample of a finite run
oWrap  out  1  one-cycle pulse on continuous-mode period wrap
oDone  out  1  one-cycle pulse after the final step of a finite run

Behaviour:
- Reset (async, iRstN=0):
  - state=IDLE; cnt=0; remaining=0.
  - oEn, oClr, oBusy, oLast, oWrap and oDone are 0; oOneHot=0.
- States: IDLE, CLR, RUN.
  - IDLE -> CLR on iStart. iCont and iLen are latched; remaining = iLen (0 is treated as 2^BITWIDTH, so remaining is BITWIDTH+1 bits wide).
  - CLR lasts exactly one cycle: oClr=1, oEn=0, cnt<=0. Then -> RUN.
  - RUN, non-stalled cycle: oEn=1; oOneHot=LSZ(cnt); on the edge, cnt<=cnt+1 and remaining<=remaining-1.
  - RUN, finite mode, when remaining==1: oLast=1 and the next state is IDLE. oDone is a registered pulse, high during the first IDLE cycle.
- Sample semantics: the core output in RUN step n equals x_n, with x_0=0. Each enabled step applies direction vector v_LSZ(n).
- LSZ rule: oOneHot has bit k set, where k is the lowest zero bit of cnt. If cnt is all-ones, oOneHot=0.
- Continuous mode, RUN step with cnt all-ones:
  - oEn=0, oClr=1, oOneHot=0.
  - cnt wraps to 0; oWrap pulses in the same cycle.
  - The sequence restarts at x_0, giving period 2^BITWIDTH. Continuous mode runs until iAbort; oLast stays 0 and oDone is never asserted.
- Finite run with iLen=0: steps cnt=0..2^BITWIDTH-1. The final step has oOneHot=0 (the core holds) and no wrap.
- Stall: iStall=1 in RUN forces oEn=0 and oClr=0 combinationally, and freezes cnt and remaining. Stall in IDLE or CLR has no effect; CLR always completes.
- Abort: iAbort=1 in CLR or RUN forces the next state to IDLE. No oDone is produced; outputs deassert next cycle. iAbort has priority over stall and last.
- iStart while busy is ignored. iStart in the oDone cycle (already IDLE) is accepted.
- oEn and oClr are never high together. In IDLE, oEn=0, oClr=0 and oOneHot=0.
- oCnt is the registered cnt.
- The only combinational input-to-output path is iStall -> oEn/oClr.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE, ST_CLR, ST_RUN;
  - the LEN_FULL (0) encoding.
- Sub-module sobolrng_lsz: combinational BITWIDTH-bit least-significant-zero one-hot detector, parameterised by BITWIDTH. It is reusable by other RNG front-ends.

Test Plan:
- BITWIDTH=4, iStart with iLen=4, iCont=0:
  - 1 cycle oClr=1;
  - then 4 RUN cycles with oCnt=0,1,2,3 and oOneHot=0001,0010,0001,0100;
  - oLast high on the oCnt=3 step;
  - oDone pulses the next cycle.
- iLen=0, BITWIDTH=4: 16 RUN steps. The final step (oCnt=15) has oOneHot=0000, oLast=1, no oWrap, then oDone.
- iCont=1, BITWIDTH=4:
  - step oCnt=15 gives oEn=0, oClr=1, oWrap=1;
  - the next step is oCnt=0 with oOneHot=0001;
  - with the core attached, oRand repeats with period 16 and covers 0..15 exactly once per period.
- Stall: iStall high for 2 cycles at oCnt=2 -> oEn=0 in those cycles and oCnt holds at 2. The run ends 2 cycles later than unstalled; the oDone count is unchanged.
- Abort and reset:
  - iAbort at oCnt=1 -> IDLE next cycle, no oDone;
  - iStart in the same cycle as oDone -> CLR next cycle;
  - iRstN low mid-RUN -> all outputs 0 immediately.
- Busy start: iStart pulsed during RUN -> ignored; run length unchanged.
